// File: rtl/vehicle_sensor_conditioner_if.sv
`default_nettype none
// ============================================================================
//  Module   : vehicle_sensor_conditioner_if
//  Purpose  : Bundles the detector input and the conditioned outputs of the
//             vehicle sensor conditioner into one connection.
//  Signals  : raw_sensor    - raw, asynchronous, bouncy detector input
//             sensor        - conditioned vehicle request to the controller
//             vehicle_count - saturating count of debounced arrivals
//             stuck_fault   - high while the detector is declared stuck
//  Modports : master - detector side (drives raw_sensor, observes outputs)
//             slave  - conditioner side
//  Revision : 1.0 - initial release
// ============================================================================
interface vehicle_sensor_conditioner_if #(
  parameter int CNT_W = 8
);
  logic             raw_sensor;
  logic             sensor;
  logic [CNT_W-1:0] vehicle_count;
  logic             stuck_fault;

  modport master (
    output raw_sensor,
    input  sensor,
    input  vehicle_count,
    input  stuck_fault
  );

  modport slave (
    input  raw_sensor,
    output sensor,
    output vehicle_count,
    output stuck_fault
  );
endinterface
`default_nettype wire

// File: rtl/vehicle_sensor_conditioner.sv
`default_nettype none
// ============================================================================
//  Module   : vehicle_sensor_conditioner
//  Purpose  : Cleans the raw side-road vehicle detector signal into the single
//             bit request used by the traffic light controller: 2-flop
//             synchroniser, debouncer, presence hold-over extension and
//             stuck-detector fault handling, plus a saturating arrival count.
//  Ports    : clk  - system clock, rising edge
//             clr  - synchronous active-high reset
//             bus  - slave side of vehicle_sensor_conditioner_if
//                    (raw_sensor in; sensor, vehicle_count, stuck_fault out,
//                    all outputs registered)
//  Revision : 1.0 - initial release
// ============================================================================
module vehicle_sensor_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int HOLD_CYCLES     = 8,
  parameter int STUCK_CYCLES    = 64,
  parameter int CNT_W           = 8
) (
  input wire                          clk,
  input wire                          clr,
  vehicle_sensor_conditioner_if.slave bus
);

  localparam int c_deb_w     = 8;
  localparam int c_deb_last  = DEBOUNCE_CYCLES - 1;
  localparam int c_hold_w    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int c_hold_last = (HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0;
  localparam int c_stuck_w   = (STUCK_CYCLES > 1) ? $clog2(STUCK_CYCLES) : 1;
  localparam int c_stuck_last = (STUCK_CYCLES > 0) ? STUCK_CYCLES - 1 : 0;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PRESENT = 2'd1,
    S_HOLD    = 2'd2,
    S_FAULT   = 2'd3
  } state_t;

  // --------------------------------------------------------------------------
  // Synchroniser and debouncer
  // --------------------------------------------------------------------------
  logic               r_sync1;
  logic               r_sync2;
  logic               r_deb;
  logic [c_deb_w-1:0] r_deb_cnt;

  logic w_differ;
  logic w_flip;
  logic w_rise;
  logic w_fall;

  // The flip is decoded combinationally so the FSM reacts on the same edge
  // the debounced level changes; it depends only on registered signals, so
  // there is still no path from raw_sensor to any output.
  always_comb begin
    w_differ = r_sync2 ^ r_deb;
    w_flip   = w_differ && (r_deb_cnt == c_deb_w'(c_deb_last));
    w_rise   = w_flip && !r_deb;
    w_fall   = w_flip && r_deb;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_deb     <= 1'b0;
      r_deb_cnt <= '0;
    end else begin
      r_sync1 <= bus.raw_sensor;
      r_sync2 <= r_sync1;
      if (w_flip) begin
        r_deb     <= ~r_deb;
        r_deb_cnt <= '0;
      end else if (w_differ) begin
        r_deb_cnt <= r_deb_cnt + c_deb_w'(1);
      end else begin
        r_deb_cnt <= '0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Presence FSM
  // --------------------------------------------------------------------------
  state_t                r_state;
  state_t                w_state_next;
  logic [c_stuck_w-1:0]  r_stuck;
  logic [c_stuck_w-1:0]  w_stuck_next;
  logic [c_hold_w-1:0]   r_hold;
  logic [c_hold_w-1:0]   w_hold_next;
  logic                  w_count_inc;
  logic                  w_sensor_next;
  logic                  w_fault_next;

  always_ff @(posedge clk) begin
    if (clr) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_stuck_next = r_stuck;
    w_hold_next  = r_hold;
    w_count_inc  = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_rise) begin
          w_state_next = S_PRESENT;
          w_stuck_next = '0;
          w_count_inc  = 1'b1;
        end
      end

      S_PRESENT: begin
        // A fall on the stuck-limit edge is a genuine departure, so it wins.
        if (w_fall) begin
          w_hold_next = '0;
          if (HOLD_CYCLES == 0) begin
            w_state_next = S_IDLE;
          end else begin
            w_state_next = S_HOLD;
          end
        end else if (r_stuck == c_stuck_w'(c_stuck_last)) begin
          w_state_next = S_FAULT;
        end else begin
          w_stuck_next = r_stuck + c_stuck_w'(1);
        end
      end

      S_HOLD: begin
        // A new arrival beats hold expiry, even on the same edge.
        if (w_rise) begin
          w_state_next = S_PRESENT;
          w_stuck_next = '0;
          w_count_inc  = 1'b1;
        end else if (r_hold == c_hold_w'(c_hold_last)) begin
          w_state_next = S_IDLE;
        end else begin
          w_hold_next = r_hold + c_hold_w'(1);
        end
      end

      S_FAULT: begin
        if (w_fall) begin
          w_state_next = S_IDLE;
        end
      end

      default: begin
        w_state_next = S_IDLE;
      end
    endcase

    w_sensor_next = (w_state_next == S_PRESENT) || (w_state_next == S_HOLD);
    w_fault_next  = (w_state_next == S_FAULT);
  end

  // --------------------------------------------------------------------------
  // Timers, arrival counter and registered outputs
  // --------------------------------------------------------------------------
  logic             r_sensor;
  logic             r_fault;
  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (clr) begin
      r_stuck  <= '0;
      r_hold   <= '0;
      r_count  <= '0;
      r_sensor <= 1'b0;
      r_fault  <= 1'b0;
    end else begin
      r_stuck  <= w_stuck_next;
      r_hold   <= w_hold_next;
      r_sensor <= w_sensor_next;
      r_fault  <= w_fault_next;
      if (w_count_inc && (r_count != {CNT_W{1'b1}})) begin
        r_count <= r_count + CNT_W'(1);
      end
    end
  end

  assign bus.sensor        = r_sensor;
  assign bus.stuck_fault   = r_fault;
  assign bus.vehicle_count = r_count;

endmodule
`default_nettype wire
